// File: rtl/pipeline_pkg.sv
// Shared decode constants, control-word layout and ID/EX register layout for the pipeline.
package pipeline_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_SLT = 6'b110101;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  localparam logic [1:0] RD_RD = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Field order fixes the bit positions: reg_write is bit 16, valid is bit 0.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [5:0] alu_fun;
    logic       sign;
    logic       valid;
  } ctrl_t;

  // ID/EX layout, MSB first: pc4 [159:128] ... ctrl [16:0].
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    ctrl_t       ctrl;
  } idex_t;

  typedef enum logic [1:0] { IMM_SEXT, IMM_ZEXT, IMM_LUI } imm_kind_e;

  typedef enum logic { ST_RUN, ST_STALL } id_state_e;

endpackage

// File: rtl/control_decoder.sv
// Instruction decode: control word, destination register, immediate kind and source/branch flags.
// Purely combinational; an all-zero instruction decodes to an all-zero control word.
module control_decoder
  import pipeline_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic [4:0]  o_dst,
  output imm_kind_e   o_imm_kind,
  output logic        o_uses_rs,
  output logic        o_uses_rt,
  output logic        o_is_beq,
  output logic        o_is_bne,
  output logic        o_is_j,
  output logic        o_is_jr
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [5:0] w_r_fun;
  logic       w_r_sign;
  logic       w_r_alu;
  logic       w_r_shift;
  logic       w_is_imm;
  logic [4:0] w_dst_sel;
  ctrl_t      w_ctrl;

  assign w_op = i_instr[31:26];
  assign w_fn = i_instr[5:0];

  always_comb begin
    w_r_fun   = ALU_ADD;
    w_r_sign  = 1'b0;
    w_r_alu   = 1'b1;
    w_r_shift = 1'b0;
    case (w_fn)
      FN_ADD:  w_r_sign = 1'b1;
      FN_ADDU: w_r_fun  = ALU_ADD;
      FN_SUB:  begin w_r_fun = ALU_SUB; w_r_sign = 1'b1; end
      FN_SUBU: w_r_fun  = ALU_SUB;
      FN_AND:  w_r_fun  = ALU_AND;
      FN_OR:   w_r_fun  = ALU_OR;
      FN_XOR:  w_r_fun  = ALU_XOR;
      FN_NOR:  w_r_fun  = ALU_NOR;
      FN_SLT:  begin w_r_fun = ALU_SLT; w_r_sign = 1'b1; end
      FN_SLTU: w_r_fun  = ALU_SLT;
      FN_SLL:  begin w_r_fun = ALU_SLL; w_r_shift = 1'b1; end
      FN_SRL:  begin w_r_fun = ALU_SRL; w_r_shift = 1'b1; end
      FN_SRA:  begin w_r_fun = ALU_SRA; w_r_shift = 1'b1; end
      default: w_r_alu  = 1'b0;
    endcase
  end

  always_comb begin
    w_ctrl     = '0;
    o_imm_kind = IMM_SEXT;
    o_uses_rs  = 1'b0;
    o_uses_rt  = 1'b0;
    o_is_beq   = 1'b0;
    o_is_bne   = 1'b0;
    o_is_j     = 1'b0;
    o_is_jr    = 1'b0;
    w_is_imm   = 1'b0;
    if (i_instr != 32'd0) begin
      w_ctrl.valid = 1'b1;
      case (w_op)
        OP_RTYPE: begin
          if (w_fn == FN_JR || w_fn == FN_JALR) begin
            o_is_jr   = 1'b1;
            o_uses_rs = 1'b1;
            if (w_fn == FN_JALR) begin
              w_ctrl.reg_write  = 1'b1;
              w_ctrl.mem_to_reg = MTR_PC4;
            end
          end else if (w_r_alu) begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_fun   = w_r_fun;
            w_ctrl.sign      = w_r_sign;
            w_ctrl.alu_src_a = w_r_shift;
            o_uses_rs        = !w_r_shift;
            o_uses_rt        = 1'b1;
          end
        end
        OP_J:   o_is_j = 1'b1;
        OP_JAL: begin
          o_is_j            = 1'b1;
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.mem_to_reg = MTR_PC4;
          w_ctrl.reg_dst    = RD_RA;
        end
        OP_BEQ, OP_BNE: begin
          o_is_beq       = (w_op == OP_BEQ);
          o_is_bne       = (w_op == OP_BNE);
          o_uses_rs      = 1'b1;
          o_uses_rt      = 1'b1;
          w_ctrl.alu_fun = ALU_SUB;
          w_ctrl.sign    = 1'b1;
        end
        OP_ADDI:  begin w_is_imm = 1'b1; w_ctrl.sign = 1'b1; end
        OP_ADDIU: w_is_imm = 1'b1;
        OP_SLTI:  begin w_is_imm = 1'b1; w_ctrl.alu_fun = ALU_SLT; w_ctrl.sign = 1'b1; end
        OP_SLTIU: begin w_is_imm = 1'b1; w_ctrl.alu_fun = ALU_SLT; end
        OP_ANDI:  begin w_is_imm = 1'b1; w_ctrl.alu_fun = ALU_AND; o_imm_kind = IMM_ZEXT; end
        OP_ORI:   begin w_is_imm = 1'b1; w_ctrl.alu_fun = ALU_OR;  o_imm_kind = IMM_ZEXT; end
        OP_LUI:   begin w_is_imm = 1'b1; o_imm_kind = IMM_LUI; end
        OP_LW: begin
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.mem_read   = 1'b1;
          w_ctrl.mem_to_reg = MTR_MEM;
          w_ctrl.reg_dst    = RD_RT;
          w_ctrl.alu_src_b  = 1'b1;
          w_ctrl.sign       = 1'b1;
          o_uses_rs         = 1'b1;
        end
        OP_SW: begin
          w_ctrl.mem_write = 1'b1;
          w_ctrl.alu_src_b = 1'b1;
          w_ctrl.sign      = 1'b1;
          o_uses_rs        = 1'b1;
          o_uses_rt        = 1'b1;
        end
        default: w_ctrl.valid = 1'b1;
      endcase
      if (w_is_imm) begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = RD_RT;
        w_ctrl.alu_src_b = 1'b1;
        o_uses_rs        = (w_op != OP_LUI);
      end
    end
  end

  assign w_dst_sel = (w_ctrl.reg_dst == RD_RA) ? 5'd31 :
                     (w_ctrl.reg_dst == RD_RT) ? i_instr[20:16] : i_instr[15:11];
  assign o_dst     = w_ctrl.reg_write ? w_dst_sel : 5'd0;

  // Writes to $0 are architecturally dropped, so they must not look like producers to hazard logic.
  always_comb begin
    o_ctrl = w_ctrl;
    if (o_dst == 5'd0) o_ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: decode, same-cycle branch/jump resolution, hazard stall FSM and the ID/EX register.
// One-cycle latency to ID_EX; hazards hold PC/IF_ID and inject a bubble, status forces a bubble without holding.
module id_stage
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [95:0]  IF_ID,
  input  logic [1:0]   status,
  output logic [4:0]   rs_addr,
  output logic [4:0]   rt_addr,
  input  logic [31:0]  rs_data,
  input  logic [31:0]  rt_data,
  input  logic         mem_MemRead,
  input  logic [4:0]   mem_dst,
  output logic         PC_IF_ID_Write,
  output logic [2:0]   select_PC_next,
  output logic [31:0]  branch_target,
  output logic [31:0]  jump_target,
  output logic [31:0]  jr_target,
  output logic [159:0] ID_EX
);

  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic [31:0] w_sext;
  logic [31:0] w_imm_ext;
  logic [30:0] w_br_sum;
  logic        w_unused_prev_pc4;
  ctrl_t       w_ctrl;
  logic [4:0]  w_dst;
  imm_kind_e   w_imm_kind;
  logic        w_uses_rs, w_uses_rt, w_is_beq, w_is_bne, w_is_j, w_is_jr;
  logic        w_src_ex, w_src_mem, w_load_use, w_ctrl_hz, w_hazard, w_status, w_issue, w_z;
  idex_t       w_dec;
  idex_t       r_id_ex;
  id_state_e   r_state;

  assign w_instr           = IF_ID[31:0];
  assign w_pc4             = IF_ID[63:32];
  assign w_unused_prev_pc4 = ^IF_ID[95:64];
  assign rs_addr           = w_instr[25:21];
  assign rt_addr           = w_instr[20:16];

  control_decoder u_dec (
    .i_instr    (w_instr),
    .o_ctrl     (w_ctrl),
    .o_dst      (w_dst),
    .o_imm_kind (w_imm_kind),
    .o_uses_rs  (w_uses_rs),
    .o_uses_rt  (w_uses_rt),
    .o_is_beq   (w_is_beq),
    .o_is_bne   (w_is_bne),
    .o_is_j     (w_is_j),
    .o_is_jr    (w_is_jr)
  );

  assign w_sext = {{16{w_instr[15]}}, w_instr[15:0]};
  always_comb begin
    case (w_imm_kind)
      IMM_ZEXT: w_imm_ext = {16'd0, w_instr[15:0]};
      IMM_LUI:  w_imm_ext = {w_instr[15:0], 16'd0};
      default:  w_imm_ext = w_sext;
    endcase
  end

  // Branch arithmetic stays inside the current 2 GB half: bit 31 of PC+4 is carried through untouched.
  assign w_br_sum      = w_pc4[30:0] + {w_sext[28:0], 2'b00};
  assign branch_target = {w_pc4[31], w_br_sum};
  assign jump_target   = {w_pc4[31:28], w_instr[25:0], 2'b00};
  assign jr_target     = rs_data;

  assign w_src_ex   = (w_uses_rs && rs_addr == r_id_ex.dst) || (w_uses_rt && rt_addr == r_id_ex.dst);
  assign w_src_mem  = (w_uses_rs && rs_addr == mem_dst)     || (w_uses_rt && rt_addr == mem_dst);
  assign w_load_use = r_id_ex.ctrl.mem_read && (r_id_ex.dst != 5'd0) && w_src_ex;
  assign w_ctrl_hz  = (w_is_beq || w_is_bne || w_is_jr) &&
                      ((r_id_ex.ctrl.reg_write && (r_id_ex.dst != 5'd0) && w_src_ex) ||
                       (mem_MemRead && (mem_dst != 5'd0) && w_src_mem));
  assign w_hazard   = w_load_use || w_ctrl_hz;
  assign w_status   = |status;
  assign w_issue    = !w_status && !w_hazard;
  assign w_z        = (w_is_beq && (rs_data == rt_data)) || (w_is_bne && (rs_data != rt_data));

  assign PC_IF_ID_Write = w_status || !w_hazard;
  assign select_PC_next = w_issue ? {w_z, w_is_j, w_is_jr} : 3'b000;

  assign w_dec = '{pc4: w_pc4, rs_data: rs_data, rt_data: rt_data, imm_ext: w_imm_ext,
                   rs: rs_addr, rt: rt_addr, dst: w_dst, ctrl: w_ctrl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_ex <= '0;
      r_state <= ST_RUN;
    end else begin
      r_id_ex <= (w_issue && w_ctrl.valid) ? w_dec : idex_t'('0);
      case (r_state)
        ST_RUN:   if (w_hazard && !w_status) r_state <= ST_STALL;
        ST_STALL: if (!w_hazard || w_status) r_state <= ST_RUN;
      endcase
    end
  end

  assign ID_EX = r_id_ex;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: combinational outputs checked each step, ID_EX checked against a queue of expectations.
module tb_id_stage;
  import pipeline_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [95:0]  IF_ID;
  logic [1:0]   status;
  logic [4:0]   rs_addr, rt_addr;
  logic [31:0]  rs_data, rt_data;
  logic         mem_MemRead;
  logic [4:0]   mem_dst;
  logic         PC_IF_ID_Write;
  logic [2:0]   select_PC_next;
  logic [31:0]  branch_target, jump_target, jr_target;
  logic [159:0] ID_EX;

  int n_checks = 0;
  int n_fail   = 0;
  logic [159:0] exp_q[$];
  logic [16:0]  c_beq, c_lw, c_add, c_jr, c_jal, c_ori, c_lui, c_addi0;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .IF_ID(IF_ID), .status(status),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .mem_MemRead(mem_MemRead), .mem_dst(mem_dst), .PC_IF_ID_Write(PC_IF_ID_Write),
    .select_PC_next(select_PC_next), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .ID_EX(ID_EX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mk_ctrl(input logic rw, input logic mr, input logic mw,
                                          input logic [1:0] mtr, input logic [1:0] rdst,
                                          input logic asa, input logic asb,
                                          input logic [5:0] fun, input logic sgn);
    return {rw, mr, mw, mtr, rdst, asa, asb, fun, sgn, 1'b1};
  endfunction

  function automatic logic [159:0] mk_idex(input logic [31:0] pc4, input logic [31:0] rsd,
                                           input logic [31:0] rtd, input logic [31:0] imm,
                                           input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] dst, input logic [16:0] ctrl);
    return {pc4, rsd, rtd, imm, rs, rt, dst, ctrl};
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic mrd, input logic [4:0] mdst,
                       input logic [1:0] st);
    @(negedge clk);
    IF_ID       = {32'hDEAD_BEEF, pc4, instr};
    rs_data     = rsd;
    rt_data     = rtd;
    mem_MemRead = mrd;
    mem_dst     = mdst;
    status      = st;
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic pcw, input logic [2:0] sel,
                              input logic [159:0] idex, input logic stall_next);
    logic [159:0] exp;
    check({tag, "_pcw"}, PC_IF_ID_Write, pcw);
    check({tag, "_sel"}, select_PC_next, sel);
    exp_q.push_back(idex);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_idex"}, ID_EX, exp);
    end
    check({tag, "_state"}, dut.r_state == ST_STALL, stall_next);
  endtask

  initial begin
    c_beq   = mk_ctrl(0, 0, 0, MTR_ALU, RD_RD, 0, 0, ALU_SUB, 1);
    c_lw    = mk_ctrl(1, 1, 0, MTR_MEM, RD_RT, 0, 1, ALU_ADD, 1);
    c_add   = mk_ctrl(1, 0, 0, MTR_ALU, RD_RD, 0, 0, ALU_ADD, 1);
    c_jr    = mk_ctrl(0, 0, 0, MTR_ALU, RD_RD, 0, 0, ALU_ADD, 0);
    c_jal   = mk_ctrl(1, 0, 0, MTR_PC4, RD_RA, 0, 0, ALU_ADD, 0);
    c_ori   = mk_ctrl(1, 0, 0, MTR_ALU, RD_RT, 0, 1, ALU_OR, 0);
    c_lui   = mk_ctrl(1, 0, 0, MTR_ALU, RD_RT, 0, 1, ALU_ADD, 0);
    c_addi0 = mk_ctrl(0, 0, 0, MTR_ALU, RD_RT, 0, 1, ALU_ADD, 1);

    rst_n = 1'b0; IF_ID = '0; status = 2'b00; rs_data = '0; rt_data = '0;
    mem_MemRead = 1'b0; mem_dst = '0;
    @(posedge clk); #1;
    check("rst_idex", ID_EX, 160'd0);
    check("rst_pcw", PC_IF_ID_Write, 1'b1);
    check("rst_sel", select_PC_next, 3'b000);
    check("rst_state", dut.r_state == ST_STALL, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // beq $8,$0 taken with equal operands
    drive(32'h1100_0004, 32'h8000_0010, 32'h0, 32'h0, 0, 5'd0, 2'b00);
    check("beq_btgt", branch_target, 32'h8000_0020);
    check("beq_jtgt", jump_target, 32'h8400_0010);
    check("beq_rs_addr", rs_addr, 5'd8);
    expect_cycle("beq", 1, 3'b100, mk_idex(32'h8000_0010, 0, 0, 32'h4, 5'd8, 5'd0, 5'd0, c_beq), 0);

    // lw $8 then dependent add: one stall, then add issues
    drive(32'h8D28_0000, 32'h8000_0014, 32'h100, 32'h55, 0, 5'd0, 2'b00);
    expect_cycle("lw1", 1, 3'b000, mk_idex(32'h8000_0014, 32'h100, 32'h55, 32'h0, 5'd9, 5'd8, 5'd8, c_lw), 0);
    drive(32'h010B_5020, 32'h8000_0018, 32'h11, 32'h22, 0, 5'd0, 2'b00);
    expect_cycle("ldu_stall", 0, 3'b000, 160'd0, 1);
    drive(32'h010B_5020, 32'h8000_0018, 32'h33, 32'h22, 1, 5'd8, 2'b00);
    expect_cycle("add_issue", 1, 3'b000, mk_idex(32'h8000_0018, 32'h33, 32'h22, 32'h5020, 5'd8, 5'd11, 5'd10, c_add), 0);

    // lw $8 then beq $8: EX stall, MEM stall, then resolve; PC+4 bit 31 preserved
    drive(32'h8D28_0000, 32'h8000_001C, 32'h100, 32'h55, 0, 5'd0, 2'b00);
    expect_cycle("lw2", 1, 3'b000, mk_idex(32'h8000_001C, 32'h100, 32'h55, 32'h0, 5'd9, 5'd8, 5'd8, c_lw), 0);
    drive(32'h1100_0004, 32'h7FFF_FFFC, 32'h0, 32'h0, 0, 5'd0, 2'b00);
    expect_cycle("br_stall1", 0, 3'b000, 160'd0, 1);
    drive(32'h1100_0004, 32'h7FFF_FFFC, 32'h0, 32'h0, 1, 5'd8, 2'b00);
    expect_cycle("br_stall2", 0, 3'b000, 160'd0, 1);
    drive(32'h1100_0004, 32'h7FFF_FFFC, 32'h0, 32'h0, 0, 5'd0, 2'b00);
    check("br_wrap_btgt", branch_target, 32'h0000_000C);
    expect_cycle("br_resolve", 1, 3'b100, mk_idex(32'h7FFF_FFFC, 0, 0, 32'h4, 5'd8, 5'd0, 5'd0, c_beq), 0);

    // jr $31
    drive(32'h03E0_0008, 32'h8000_0044, 32'h8000_0100, 32'h9, 0, 5'd0, 2'b00);
    check("jr_tgt", jr_target, 32'h8000_0100);
    expect_cycle("jr", 1, 3'b001, mk_idex(32'h8000_0044, 32'h8000_0100, 32'h9, 32'h8, 5'd31, 5'd0, 5'd0, c_jr), 0);

    // add $10 then bne $10,$0: control hazard on EX producer, then taken
    drive(32'h010B_5020, 32'h8000_0048, 32'h1, 32'h2, 0, 5'd0, 2'b00);
    expect_cycle("add2", 1, 3'b000, mk_idex(32'h8000_0048, 32'h1, 32'h2, 32'h5020, 5'd8, 5'd11, 5'd10, c_add), 0);
    drive(32'h1540_0002, 32'h8000_004C, 32'h5, 32'h0, 0, 5'd0, 2'b00);
    expect_cycle("bne_stall", 0, 3'b000, 160'd0, 1);
    drive(32'h1540_0002, 32'h8000_004C, 32'h5, 32'h0, 0, 5'd0, 2'b00);
    check("bne_btgt", branch_target, 32'h8000_0054);
    expect_cycle("bne_taken", 1, 3'b100, mk_idex(32'h8000_004C, 32'h5, 32'h0, 32'h2, 5'd10, 5'd0, 5'd0, c_beq), 0);

    // beq not taken
    drive(32'h1100_0004, 32'h8000_0050, 32'h3, 32'h4, 0, 5'd0, 2'b00);
    expect_cycle("beq_nt", 1, 3'b000, mk_idex(32'h8000_0050, 32'h3, 32'h4, 32'h4, 5'd8, 5'd0, 5'd0, c_beq), 0);

    // status overrides a load-use hazard
    drive(32'h8D28_0000, 32'h8000_0054, 32'h100, 32'h55, 0, 5'd0, 2'b00);
    expect_cycle("lw3", 1, 3'b000, mk_idex(32'h8000_0054, 32'h100, 32'h55, 32'h0, 5'd9, 5'd8, 5'd8, c_lw), 0);
    drive(32'h010B_5020, 32'h8000_0058, 32'h1, 32'h2, 0, 5'd0, 2'b01);
    expect_cycle("status_ovr", 1, 3'b000, 160'd0, 0);

    // jal, ori (zero-extend), lui, bubble, addi to $0
    drive(32'h0C00_0040, 32'h8000_0060, 32'h0, 32'h0, 0, 5'd0, 2'b00);
    check("jal_jtgt", jump_target, 32'h8000_0100);
    expect_cycle("jal", 1, 3'b010, mk_idex(32'h8000_0060, 0, 0, 32'h40, 5'd0, 5'd0, 5'd31, c_jal), 0);
    drive(32'h3509_8001, 32'h8000_0064, 32'hA, 32'hB, 0, 5'd0, 2'b00);
    expect_cycle("ori", 1, 3'b000, mk_idex(32'h8000_0064, 32'hA, 32'hB, 32'h0000_8001, 5'd8, 5'd9, 5'd9, c_ori), 0);
    drive(32'h3C03_1234, 32'h8000_0068, 32'h0, 32'h0, 0, 5'd0, 2'b00);
    expect_cycle("lui", 1, 3'b000, mk_idex(32'h8000_0068, 0, 0, 32'h1234_0000, 5'd0, 5'd3, 5'd3, c_lui), 0);
    drive(32'h0, 32'h8000_006C, 32'h77, 32'h88, 1, 5'd0, 2'b00);
    expect_cycle("bubble", 1, 3'b000, 160'd0, 0);
    drive(32'h2020_0005, 32'h8000_0070, 32'h1, 32'h2, 0, 5'd0, 2'b00);
    expect_cycle("addi_r0", 1, 3'b000, mk_idex(32'h8000_0070, 32'h1, 32'h2, 32'h5, 5'd1, 5'd0, 5'd0, c_addi0), 0);

    // asynchronous reset while a hazard is pending and ID_EX is non-zero
    drive(32'h8D28_0000, 32'h8000_0074, 32'h100, 32'h55, 0, 5'd0, 2'b00);
    expect_cycle("lw4", 1, 3'b000, mk_idex(32'h8000_0074, 32'h100, 32'h55, 32'h0, 5'd9, 5'd8, 5'd8, c_lw), 0);
    drive(32'h010B_5020, 32'h8000_0078, 32'h1, 32'h2, 0, 5'd0, 2'b00);
    check("pre_rst_pcw", PC_IF_ID_Write, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_idex", ID_EX, 160'd0);
    check("async_rst_pcw", PC_IF_ID_Write, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    // reset during STALL returns to RUN and the held add issues
    drive(32'h8D28_0000, 32'h8000_007C, 32'h100, 32'h55, 0, 5'd0, 2'b00);
    expect_cycle("lw5", 1, 3'b000, mk_idex(32'h8000_007C, 32'h100, 32'h55, 32'h0, 5'd9, 5'd8, 5'd8, c_lw), 0);
    drive(32'h010B_5020, 32'h8000_0080, 32'h1, 32'h2, 0, 5'd0, 2'b00);
    expect_cycle("stall_pre_rst", 0, 3'b000, 160'd0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("stall_rst_state", dut.r_state == ST_STALL, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    drive(32'h010B_5020, 32'h8000_0080, 32'h1, 32'h2, 0, 5'd0, 2'b00);
    expect_cycle("post_rst_add", 1, 3'b000, mk_idex(32'h8000_0080, 32'h1, 32'h2, 32'h5020, 5'd8, 5'd11, 5'd10, c_add), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
